wavepool_issue_slots: RTL
=========================

WAVEPOOL_ISSUE_SLOTS -- requirements
Module: wavepool_issue_slots

Interface
REQ-001 Parameter NUM_WF, default 8: number of wavefront slots; legal wfids are 0..NUM_WF-1, and NUM_WF SHALL be at most 64.
REQ-002 clk  in  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 fetch_valid  in  1  instruction-write strobe from fetch.
REQ-005 fetch_wfid / fetch_pc / fetch_instr  in  6/32/32  target slot, instruction PC, instruction word.
REQ-006 dispatch_valid  in  1  wavefront-base write strobe.
REQ-007 dispatch_wfid / dispatch_vgpr_base / dispatch_sgpr_base / dispatch_lds_base  in  6/10/9/16  target slot and its register/LDS bases.
REQ-008 halt_valid / halt_wfid  in  1/6  clear the pending instruction of one slot.
REQ-009 decode_stall  in  1  decode cannot accept an instruction this cycle.
REQ-010 wave_instr_valid / wave_instr_pc / wave_instr / wave_wfid  out  1/32/32/6  registered issue toward the wavepool-to-decode flop stage.
REQ-011 wave_vgpr_base / wave_sgpr_base / wave_lds_base  out  10/9/16  bases of the issued wave, registered.
REQ-012 slot_full  out  NUM_WF  per-slot "instruction pending" flags, registered.
REQ-013 overflow_err  out  1  sticky flag for an illegal write.

Function
REQ-014 Each slot SHALL hold full, pc[31:0], instr[31:0], vgpr_base, sgpr_base and lds_base; slot_full[i] SHALL equal the full bit of slot i.
REQ-015 A fetch write with fetch_valid=1 to an empty slot SHALL load pc and instr and set full at that edge.
REQ-016 A fetch write to a slot that is full and not being issued in the same cycle SHALL be dropped, leave the slot unchanged, and set overflow_err.
REQ-017 A fetch write to the slot being issued in the same cycle SHALL be accepted; the slot stays full with the new data, and the issued output carries the old data.
REQ-018 A fetch or dispatch with wfid >= NUM_WF SHALL be ignored and SHALL set overflow_err.
REQ-019 dispatch_valid=1 SHALL load the three bases of slot dispatch_wfid at that edge, independent of the full bit.
REQ-020 A fetch and a dispatch to the same wfid in the same cycle SHALL both take effect.
REQ-021 halt_valid=1 SHALL clear full of slot halt_wfid at that edge.
REQ-022 A halt SHALL take precedence over a same-cycle fetch to the same slot; the fetch is dropped without setting overflow_err.
REQ-023 A halted slot SHALL be excluded from issue selection in the halt cycle.
REQ-024 Issue selection (combinational, from registered state) SHALL pick the first full, non-halted slot scanning rr_ptr, rr_ptr+1, ... modulo NUM_WF.
REQ-025 When decode_stall=0 and a slot is selected, the next edge SHALL register wave_instr_valid=1 with that slot's pc, instr, index (zero-extended to 6 bits) and bases.
REQ-026 On that issue edge, the issued slot SHALL be cleared, subject to REQ-017.
REQ-027 On that issue edge, rr_ptr SHALL be set to (selected+1) mod NUM_WF.
REQ-028 When decode_stall=1 or no slot is eligible, the next edge SHALL register wave_instr_valid=0; the data outputs, slots and rr_ptr SHALL hold.
REQ-029 At most one instruction SHALL issue per cycle.
REQ-030 Latency: a fetch sampled at edge N SHALL make wave_instr_valid=1 no earlier than after edge N+1.
REQ-031 Base fields written by a dispatch at edge N SHALL be visible on issue at edge N+1 or later, never at edge N.

Reset
REQ-032 While rst=1, wave_instr_valid, all data outputs, slot_full, every slot field, rr_ptr and overflow_err SHALL be 0 immediately, without waiting for clk.
REQ-033 Deassertion of rst SHALL be synchronised by the user; the block SHALL accept a fetch on the first edge after deassertion.
REQ-034 A reset asserted mid-operation SHALL discard all pending slots, and no issue SHALL occur from pre-reset state.

Verification
REQ-035 Single fetch: wfid=3, pc=0x100, instr=0xBF810000, with bases previously dispatched 0x040/0x020/0x1000 and decode_stall=0 -> one cycle later, a one-cycle wave_instr_valid=1 with wfid=3 and those values; slot_full[3] clears.
REQ-036 Round-robin: slots 1, 2 and 5 filled in the same cycle -> issue order 1, 2, 5 on consecutive cycles; rr_ptr ends at 6.
REQ-037 Stall: slot 0 full and decode_stall=1 for 3 cycles -> wave_instr_valid=0 for those cycles; issue occurs on the edge after decode_stall falls.
REQ-038 Overflow and collision: fetch to full slot 4 while stalled -> data unchanged and overflow_err=1; fetch to slot 4 in its issue cycle -> old data issued and slot_full[4] stays 1.
REQ-039 Halt: halt_wfid=2 together with a fetch to wfid=2 while slot 2 is full -> slot_full[2]=0, nothing issued from slot 2, overflow_err unchanged.
REQ-040 Async reset mid-stream: rst pulsed between clock edges with 4 slots full -> all outputs 0 before the next edge; no issue follows.

Source files
------------

// File: rtl/wavepool_issue_slots.sv
// ---------------------------------------------------------------------------
// wavepool_issue_slots
//
// Per-wavefront instruction buffer sitting between fetch and decode. Each of
// NUM_WF slots holds one pending instruction (pc, instr) plus the wavefront's
// VGPR/SGPR/LDS bases. A round-robin picker issues at most one pending
// instruction per cycle into a registered output stage.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   fetch_*_i                  instruction write into slot fetch_wfid_i
//   dispatch_*_i               base-register write into slot dispatch_wfid_i
//   halt_valid_i, halt_wfid_i  drop the pending instruction of one slot
//   decode_stall_i             decode cannot accept an instruction this cycle
//   wave_*_o                   registered issue toward decode
//   slot_full_o                per-slot pending flags
//   overflow_err_o             sticky: write to a busy slot or an illegal wfid
//
// NUM_WF must be in 1..64 (wfids are 6 bits wide).
// ---------------------------------------------------------------------------
module wavepool_issue_slots #(
    parameter int NUM_WF = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_valid_i,
    input  logic [5:0]        fetch_wfid_i,
    input  logic [31:0]       fetch_pc_i,
    input  logic [31:0]       fetch_instr_i,
    input  logic              dispatch_valid_i,
    input  logic [5:0]        dispatch_wfid_i,
    input  logic [9:0]        dispatch_vgpr_base_i,
    input  logic [8:0]        dispatch_sgpr_base_i,
    input  logic [15:0]       dispatch_lds_base_i,
    input  logic              halt_valid_i,
    input  logic [5:0]        halt_wfid_i,
    input  logic              decode_stall_i,
    output logic              wave_instr_valid_o,
    output logic [31:0]       wave_instr_pc_o,
    output logic [31:0]       wave_instr_o,
    output logic [5:0]        wave_wfid_o,
    output logic [9:0]        wave_vgpr_base_o,
    output logic [8:0]        wave_sgpr_base_o,
    output logic [15:0]       wave_lds_base_o,
    output logic [NUM_WF-1:0] slot_full_o,
    output logic              overflow_err_o
);

    // Slot storage
    logic [NUM_WF-1:0] full_q, full_d;
    logic [31:0]       pc_q    [NUM_WF];
    logic [31:0]       instr_q [NUM_WF];
    logic [9:0]        vgpr_q  [NUM_WF];
    logic [8:0]        sgpr_q  [NUM_WF];
    logic [15:0]       lds_q   [NUM_WF];
    logic [5:0]        rr_ptr_q, rr_ptr_d;
    logic              ovf_q, ovf_d;

    // Output stage
    logic              wave_valid_q;
    logic [31:0]       wave_pc_q, wave_instr_q;
    logic [5:0]        wave_wfid_q;
    logic [9:0]        wave_vgpr_q;
    logic [8:0]        wave_sgpr_q;
    logic [15:0]       wave_lds_q;

    // Per-slot decode of the three write ports. An out-of-range wfid matches
    // no slot, which is how illegal writes are detected below.
    logic [NUM_WF-1:0] fetch_hit, disp_hit, halt_hit, elig, sel_oh;

    always_comb begin
        fetch_hit = '0;
        disp_hit  = '0;
        halt_hit  = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            fetch_hit[i] = fetch_valid_i    && (fetch_wfid_i    == 6'(i));
            disp_hit[i]  = dispatch_valid_i && (dispatch_wfid_i == 6'(i));
            halt_hit[i]  = halt_valid_i     && (halt_wfid_i     == 6'(i));
        end
    end

    // A slot being halted this cycle may not issue.
    assign elig = full_q & ~halt_hit;

    // Round-robin pick: rotate the eligible vector so rr_ptr lands at bit 0,
    // take the lowest set bit, then rotate the offset back.
    logic [2*NUM_WF-1:0] elig2;
    logic [NUM_WF-1:0]   elig_rot;
    logic                sel_found;
    logic [6:0]          sel_off, sel_sum, sel_wrap, rr_nxt;
    logic [5:0]          sel_idx;
    logic                issue;

    always_comb begin
        elig2     = {elig, elig};
        elig_rot  = NUM_WF'(elig2 >> rr_ptr_q);
        sel_found = 1'b0;
        sel_off   = '0;
        for (int k = NUM_WF - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                sel_found = 1'b1;
                sel_off   = 7'(k);
            end
        end
        sel_sum  = {1'b0, rr_ptr_q} + sel_off;
        sel_wrap = (sel_sum >= 7'(NUM_WF)) ? sel_sum - 7'(NUM_WF) : sel_sum;
        sel_idx  = 6'(sel_wrap);
        issue    = sel_found && !decode_stall_i;
        rr_nxt   = {1'b0, sel_idx} + 7'd1;
        rr_ptr_d = issue ? ((rr_nxt == 7'(NUM_WF)) ? 6'd0 : 6'(rr_nxt)) : rr_ptr_q;
    end

    // Data of the selected slot
    logic [31:0] sel_pc, sel_instr;
    logic [9:0]  sel_vgpr;
    logic [8:0]  sel_sgpr;
    logic [15:0] sel_lds;

    always_comb begin
        sel_oh    = '0;
        sel_pc    = '0;
        sel_instr = '0;
        sel_vgpr  = '0;
        sel_sgpr  = '0;
        sel_lds   = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            if (sel_idx == 6'(i)) begin
                sel_oh[i] = issue;
                sel_pc    = pc_q[i];
                sel_instr = instr_q[i];
                sel_vgpr  = vgpr_q[i];
                sel_sgpr  = sgpr_q[i];
                sel_lds   = lds_q[i];
            end
        end
    end

    // Fetch acceptance. A full slot is only writable when it issues in the
    // same cycle (the output takes the old data). A halt to the same slot
    // silently wins over the fetch.
    logic fetch_oor, disp_oor, f_halted, f_busy, fetch_acc;

    always_comb begin
        fetch_oor = fetch_valid_i    && !(|fetch_hit);
        disp_oor  = dispatch_valid_i && !(|disp_hit);
        f_halted  = |(fetch_hit & halt_hit);
        f_busy    = |(fetch_hit & full_q & ~sel_oh);
        fetch_acc = (|fetch_hit) && !f_halted && !f_busy;
        ovf_d     = ovf_q | fetch_oor | disp_oor | (!f_halted && f_busy);
        full_d    = (full_q & ~sel_oh & ~halt_hit) | (fetch_acc ? fetch_hit : '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q       <= '0;
            rr_ptr_q     <= '0;
            ovf_q        <= 1'b0;
            wave_valid_q <= 1'b0;
            wave_pc_q    <= '0;
            wave_instr_q <= '0;
            wave_wfid_q  <= '0;
            wave_vgpr_q  <= '0;
            wave_sgpr_q  <= '0;
            wave_lds_q   <= '0;
            for (int i = 0; i < NUM_WF; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                vgpr_q[i]  <= '0;
                sgpr_q[i]  <= '0;
                lds_q[i]   <= '0;
            end
        end else begin
            full_q       <= full_d;
            rr_ptr_q     <= rr_ptr_d;
            ovf_q        <= ovf_d;
            wave_valid_q <= issue;
            // Data outputs hold while nothing issues.
            if (issue) begin
                wave_pc_q    <= sel_pc;
                wave_instr_q <= sel_instr;
                wave_wfid_q  <= sel_idx;
                wave_vgpr_q  <= sel_vgpr;
                wave_sgpr_q  <= sel_sgpr;
                wave_lds_q   <= sel_lds;
            end
            for (int i = 0; i < NUM_WF; i++) begin
                if (fetch_acc && fetch_hit[i]) begin
                    pc_q[i]    <= fetch_pc_i;
                    instr_q[i] <= fetch_instr_i;
                end
                if (disp_hit[i]) begin
                    vgpr_q[i] <= dispatch_vgpr_base_i;
                    sgpr_q[i] <= dispatch_sgpr_base_i;
                    lds_q[i]  <= dispatch_lds_base_i;
                end
            end
        end
    end

    assign wave_instr_valid_o = wave_valid_q;
    assign wave_instr_pc_o    = wave_pc_q;
    assign wave_instr_o       = wave_instr_q;
    assign wave_wfid_o        = wave_wfid_q;
    assign wave_vgpr_base_o   = wave_vgpr_q;
    assign wave_sgpr_base_o   = wave_sgpr_q;
    assign wave_lds_base_o    = wave_lds_q;
    assign slot_full_o        = full_q;
    assign overflow_err_o     = ovf_q;

endmodule
